axi_rd_arbiter: RTL and testbench

Two-port AXI3 read-channel arbiter that shares the core's single AXI master read port between the instruction cache (port 0) and the data cache / uncached load path (port 1). It holds one outstanding burst at a time and registers the winning AR request before issuing it. It routes R beats back only to the granted requester and releases the grant on the last beat. It sits between the two cache refill engines and the top-level AXI master interface, and it never touches the write channels.

---
 rtl/axi_rd_arbiter_if.sv | 30 +++
 rtl/axi_rd_arbiter.sv | 99 +++++++++
 tb/tb_axi_rd_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: AXI3 read address + read data channel bundle.
// master drives AR and rready; slave drives arready and the R beat.
interface axi_rd_arbiter_if #(
    parameter int ID_W  = 4,
    parameter int LEN_W = 4
);
    logic [ID_W-1:0]  arid;
    logic [31:0]      araddr;
    logic [LEN_W-1:0] arlen;
    logic [2:0]       arsize;
    logic [1:0]       arburst;
    logic             arvalid;
    logic             arready;
    logic [ID_W-1:0]  rid;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rlast;
    logic             rvalid;
    logic             rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI3 read port between ICache (s0) and DCache (s1),
// one outstanding burst at a time, round-robin on ties, len_err on bad beat counts.
module axi_rd_arbiter #(
    parameter int ID_W  = 4,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    axi_rd_arbiter_if.slave  s0,
    axi_rd_arbiter_if.slave  s1,
    axi_rd_arbiter_if.master m,
    output logic [1:0]       m_arlock_o,
    output logic [3:0]       m_arcache_o,
    output logic [2:0]       m_arprot_o,
    output logic             len_err_o
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e           state_q, state_d;
    logic             grant_q, last_grant_q, len_err_q;
    logic [ID_W-1:0]  id_q;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] len_q;
    logic [2:0]       size_q;
    logic [1:0]       burst_q;
    logic [LEN_W:0]   cnt_q;
    logic             req, win, sel0, sel1, beat;

    assign req  = s0.arvalid | s1.arvalid;
    // on a tie the side not served last wins
    assign win  = (s0.arvalid & s1.arvalid) ? ~last_grant_q : s1.arvalid;
    assign sel0 = (state_q == DATA) & ~grant_q;
    assign sel1 = (state_q == DATA) & grant_q;
    assign beat = m.rvalid & m.rready;

    // rst gates arready so nothing is accepted while reset is held
    assign s0.arready = (state_q == IDLE) & ~rst & s0.arvalid & ~win;
    assign s1.arready = (state_q == IDLE) & ~rst & s1.arvalid & win;

    assign m.arid    = id_q;
    assign m.araddr  = addr_q;
    assign m.arlen   = len_q;
    assign m.arsize  = size_q;
    assign m.arburst = burst_q;
    assign m.arvalid = state_q == ADDR;
    assign m.rready  = (sel0 & s0.rready) | (sel1 & s1.rready);

    assign m_arlock_o  = '0;
    assign m_arcache_o = '0;
    assign m_arprot_o  = '0;
    assign len_err_o   = len_err_q;

    assign s0.rvalid = sel0 & m.rvalid;
    assign s0.rid    = sel0 ? m.rid : '0;
    assign s0.rdata  = sel0 ? m.rdata : '0;
    assign s0.rresp  = sel0 ? m.rresp : '0;
    assign s0.rlast  = sel0 & m.rlast;
    assign s1.rvalid = sel1 & m.rvalid;
    assign s1.rid    = sel1 ? m.rid : '0;
    assign s1.rdata  = sel1 ? m.rdata : '0;
    assign s1.rresp  = sel1 ? m.rresp : '0;
    assign s1.rlast  = sel1 & m.rlast;

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && req) state_d = ADDR;
        if (state_q == ADDR && m.arready) state_d = DATA;
        if (beat && m.rlast) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            len_err_q    <= 1'b0;
            id_q         <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            cnt_q        <= '0;
        end else begin
            state_q   <= state_d;
            len_err_q <= beat & m.rlast & (cnt_q != {1'b0, len_q});
            if (state_q == IDLE && req) begin
                grant_q <= win;
                id_q    <= win ? s1.arid    : s0.arid;
                addr_q  <= win ? s1.araddr  : s0.araddr;
                len_q   <= win ? s1.arlen   : s0.arlen;
                size_q  <= win ? s1.arsize  : s0.arsize;
                burst_q <= win ? s1.arburst : s0.arburst;
            end
            if (state_q == ADDR && m.arready) cnt_q <= '0;
            else if (beat) cnt_q <= cnt_q + 1'b1;
            if (beat && m.rlast) last_grant_q <= grant_q;
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: randomized bench with a slave/requester model; expected grant
// order, routing and len_err come from the arbitration rules, not the RTL.
module tb_axi_rd_arbiter;
    localparam int ID_W  = 4;
    localparam int LEN_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_rd_arbiter_if #(.ID_W(ID_W), .LEN_W(LEN_W)) s0_if ();
    axi_rd_arbiter_if #(.ID_W(ID_W), .LEN_W(LEN_W)) s1_if ();
    axi_rd_arbiter_if #(.ID_W(ID_W), .LEN_W(LEN_W)) m_if ();

    logic [1:0] lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic       len_err;

    axi_rd_arbiter #(.ID_W(ID_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .s0(s0_if), .s1(s1_if), .m(m_if),
        .m_arlock_o(lock), .m_arcache_o(cache), .m_arprot_o(prot), .len_err_o(len_err)
    );

    logic [ID_W-1:0]  arid[2];
    logic [31:0]      araddr[2];
    logic [LEN_W-1:0] arlen[2];
    logic [2:0]       arsize[2];
    logic [1:0]       arburst[2];
    logic             arvalid[2], rready[2];
    logic             arready[2], rvalid[2], rlast[2];
    logic [ID_W-1:0]  rid[2];
    logic [31:0]      rdata[2];
    logic [1:0]       rresp[2];

    assign s0_if.arid = arid[0];       assign s1_if.arid = arid[1];
    assign s0_if.araddr = araddr[0];   assign s1_if.araddr = araddr[1];
    assign s0_if.arlen = arlen[0];     assign s1_if.arlen = arlen[1];
    assign s0_if.arsize = arsize[0];   assign s1_if.arsize = arsize[1];
    assign s0_if.arburst = arburst[0]; assign s1_if.arburst = arburst[1];
    assign s0_if.arvalid = arvalid[0]; assign s1_if.arvalid = arvalid[1];
    assign s0_if.rready = rready[0];   assign s1_if.rready = rready[1];
    assign arready[0] = s0_if.arready; assign arready[1] = s1_if.arready;
    assign rvalid[0] = s0_if.rvalid;   assign rvalid[1] = s1_if.rvalid;
    assign rlast[0] = s0_if.rlast;     assign rlast[1] = s1_if.rlast;
    assign rid[0] = s0_if.rid;         assign rid[1] = s1_if.rid;
    assign rdata[0] = s0_if.rdata;     assign rdata[1] = s1_if.rdata;
    assign rresp[0] = s0_if.rresp;     assign rresp[1] = s1_if.rresp;

    int nvec = 0;
    int nerr = 0;
    int last_served = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference arbitration: lone requester wins, tie goes to the side not served last
    function automatic int pick();
        if (arvalid[0] && arvalid[1]) return (last_served == 0) ? 1 : 0;
        return arvalid[1] ? 1 : 0;
    endfunction

    task automatic clear_inputs();
        for (int p = 0; p < 2; p++) begin
            arvalid[p] = 0; rready[p] = 0; arid[p] = '0; araddr[p] = '0;
            arlen[p] = '0; arsize[p] = '0; arburst[p] = '0;
        end
        m_if.arready = 0; m_if.rvalid = 0; m_if.rlast = 0;
        m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0;
    endtask

    task automatic set_req(input int p, input logic [31:0] addr, input logic [LEN_W-1:0] len);
        arid[p] = ID_W'($urandom);
        araddr[p] = addr;
        arlen[p] = len;
        arsize[p] = 3'($urandom_range(0, 2));
        arburst[p] = 2'($urandom_range(0, 2));
        arvalid[p] = 1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_arready0"}, arready[0], 0);
        check({tag, "_arready1"}, arready[1], 0);
        check({tag, "_m_arvalid"}, m_if.arvalid, 0);
        check({tag, "_rvalid0"}, rvalid[0], 0);
        check({tag, "_rvalid1"}, rvalid[1], 0);
        check({tag, "_m_rready"}, m_if.rready, 0);
        check({tag, "_len_err"}, len_err, 0);
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 0;
        last_served = 0;
    endtask

    // one full burst: accept, AR phase with ar_delay stall cycles, nbeats R beats,
    // then the len_err cycle. Returns at the check point of the cycle after rlast.
    task automatic run_burst(input int nbeats, input int ar_delay, input bit toggle_rr,
                             input bit gaps, input int abort_at, input bit immediate);
        int w, o, t, i;
        logic [ID_W-1:0]  eid;
        logic [31:0]      ea, dat;
        logic [LEN_W-1:0] el;
        logic [2:0]       es;
        logic [1:0]       eb;
        logic             rr;
        w = pick();
        o = 1 - w;
        #1;
        t = 0;
        while (!(arready[0] || arready[1]) && t < 20) begin
            @(negedge clk); #1; t++;
        end
        check("ar_wait_expired", t >= 20, 0);
        if (immediate) check("accept_latency", t, 0);
        check("ar_winner", arready[w], 1);
        check("ar_loser", arready[o], 0);
        eid = arid[w]; ea = araddr[w]; el = arlen[w]; es = arsize[w]; eb = arburst[w];
        for (int c = 0; c <= ar_delay; c++) begin
            @(negedge clk);
            if (c == 0) arvalid[w] = 0;
            m_if.arready = (c == ar_delay);
            #1;
            check("m_arvalid", m_if.arvalid, 1);
            check("m_araddr", m_if.araddr, ea);
            check("m_arfields", {m_if.arid, m_if.arlen, m_if.arsize, m_if.arburst}, {eid, el, es, eb});
            check("m_arconst", {lock, cache, prot}, 0);
            check("addr_arready", arready[0] | arready[1], 0);
            check("addr_m_rready", m_if.rready, 0);
            check("addr_rvalid", rvalid[0] | rvalid[1], 0);
            check("addr_len_err", len_err, 0);
        end
        i = 0; t = 0; rr = 0;
        while (i < nbeats && t < 400) begin
            @(negedge clk);
            m_if.arready = 0;
            dat = ea ^ 32'(i);
            m_if.rvalid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            m_if.rdata = dat;
            m_if.rid = eid;
            m_if.rresp = 2'(i);
            m_if.rlast = (i == nbeats - 1);
            rr = toggle_rr ? ~rr : (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
            rready[w] = rr;
            rready[o] = 1'($urandom_range(0, 1));
            #1;
            check("m_rready", m_if.rready, rr);
            check("rvalid_win", rvalid[w], m_if.rvalid);
            check("rvalid_other", rvalid[o], 0);
            check("rfields_other", {rid[o], rdata[o], rresp[o], rlast[o]}, 0);
            check("data_len_err", len_err, 0);
            if (m_if.rvalid) begin
                check("rdata", rdata[w], dat);
                check("rmeta", {rid[w], rresp[w], rlast[w]}, {eid, 2'(i), m_if.rlast});
            end
            if (m_if.rvalid && rr) i++;
            t++;
            if (abort_at >= 0 && i == abort_at) begin
                #2;
                rst = 1;
                #1;
                check_quiet("async_rst");
                clear_inputs();
                @(negedge clk); @(negedge clk);
                rst = 0;
                last_served = 0;
                return;
            end
        end
        check("beat_wait_expired", t >= 400, 0);
        @(negedge clk);
        m_if.rvalid = 0; m_if.rlast = 0; rready[0] = 0; rready[1] = 0;
        #1;
        check("len_err", len_err, (nbeats != int'(el) + 1));
        check("idle_m_rready", m_if.rready, 0);
        check("idle_rvalid", rvalid[0] | rvalid[1], 0);
        check("idle_m_arvalid", m_if.arvalid, 0);
        last_served = w;
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        set_req(0, 32'h1FC0_0000, 4'd15);
        repeat (2) @(negedge clk);
        #1;
        check_quiet("in_rst");
        @(negedge clk);
        rst = 0;
        last_served = 0;
        run_burst(16, 0, 0, 0, -1, 1);

        do_reset();
        set_req(0, 32'h0000_1000, 4'd3);
        set_req(1, 32'h8000_2000, 4'd1);
        run_burst(2, 0, 0, 0, -1, 1);
        set_req(1, 32'h8000_3000, 4'd2);
        run_burst(4, 1, 0, 1, -1, 1);
        run_burst(3, 0, 0, 0, -1, 1);

        set_req(1, 32'h4000_0040, 4'd7);
        run_burst(8, 5, 1, 0, -1, 1);

        set_req(0, 32'h2000_0000, 4'd7);
        run_burst(3, 0, 0, 0, -1, 1);
        @(negedge clk); #1;
        check("len_err_single", len_err, 0);

        set_req(0, 32'h1FC0_0100, 4'd15);
        run_burst(16, 0, 0, 0, 4, 1);
        set_req(1, 32'h3000_0000, 4'd0);
        run_burst(1, 0, 0, 0, -1, 1);

        for (int r = 0; r < 30; r++) begin
            int mask;
            mask = $urandom_range(1, 3);
            for (int p = 0; p < 2; p++)
                if (mask[p]) set_req(p, $urandom, LEN_W'($urandom));
            while (arvalid[0] || arvalid[1]) begin
                int nb;
                nb = $urandom_range(0, 1) ? int'(arlen[pick()]) + 1 : $urandom_range(1, 16);
                run_burst(nb, $urandom_range(0, 3), 0, 1, -1, 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
